// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, opcode type and flag positions for the ALU stage
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t OP_AND = 3'b000;
  localparam alu_op_t OP_OR  = 3'b001;
  localparam alu_op_t OP_XOR = 3'b010;
  localparam alu_op_t OP_ADD = 3'b011;
  localparam alu_op_t OP_SUB = 3'b100;
  localparam alu_op_t OP_SLT = 3'b101;
  localparam alu_op_t OP_SLL = 3'b110;
  localparam alu_op_t OP_SRL = 3'b111;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int NUM_FLAGS  = 3;

endpackage

// File: rtl/alu_pipe_stage_if.sv
// rtl/alu_pipe_stage_if.sv - operand/result handshake bundle of the ALU pipe stage
interface alu_pipe_stage_if #(
  parameter int WIDTH = 32
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_t          op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic [15:0]      op_count;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, carry, ovf, op_count
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, carry, ovf, op_count
  );

endinterface

// File: rtl/alu_func_unit.sv
// rtl/alu_func_unit.sv - combinational ALU function: a, b, op -> y, zero, carry, ovf
module alu_func_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);
  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] and_y;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH-1:0] xor_y;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             is_sub;
  logic             slt;

  // The shared 32-bit units only fit the default width; other widths use operators.
  generate
    if (WIDTH == 32) begin : g_units
      and_32bit u_and (.a(a), .b(b), .y(and_y));
      or_32bit  u_or  (.a(a), .b(b), .y(or_y));
      xor_32bit u_xor (.a(a), .b(b), .y(xor_y));
    end else begin : g_ops
      assign and_y = a & b;
      assign or_y  = a | b;
      assign xor_y = a ^ b;
    end
  endgenerate

  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    slt    = $signed(a) < $signed(b);
    y      = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_AND: y = and_y;
      OP_OR:  y = or_y;
      OP_XOR: y = xor_y;
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y     = sum[WIDTH-1:0];
        carry = ~sum[WIDTH];
        ovf   = (a[MSB] != b[MSB]) & (sum[MSB] != a[MSB]);
      end
      OP_SLT: y = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL: y = a << b[SHW-1:0];
      OP_SRL: y = a >> b[SHW-1:0];
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/and_32bit.sv
// rtl/and_32bit.sv - 32-bit bitwise AND unit
module and_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a & b;
endmodule

// File: rtl/or_32bit.sv
// rtl/or_32bit.sv - 32-bit bitwise OR unit
module or_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a | b;
endmodule

// File: rtl/xor_32bit.sv
// rtl/xor_32bit.sv - 32-bit bitwise XOR unit
module xor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/alu_pipe_stage.sv
// rtl/alu_pipe_stage.sv - two-stage registered ALU with valid/ready on both sides
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_pipe_stage_if.slave  bus
);
  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     s1_a_q, s1_a_d;
  logic [WIDTH-1:0]     s1_b_q, s1_b_d;
  alu_op_t              s1_op_q, s1_op_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     y_q, y_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [15:0]          op_count_q, op_count_d;

  logic             s2_adv;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] fu_y;
  logic             fu_zero;
  logic             fu_carry;
  logic             fu_ovf;

  alu_func_unit #(.WIDTH(WIDTH)) u_func (
    .a     (s1_a_q),
    .b     (s1_b_q),
    .op    (s1_op_q),
    .y     (fu_y),
    .zero  (fu_zero),
    .carry (fu_carry),
    .ovf   (fu_ovf)
  );

  always_comb begin
    s2_adv   = !out_valid_q | bus.out_ready;
    in_ready = !s1_valid_q | s2_adv;
    accept   = bus.in_valid & in_ready;

    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_op_d    = bus.op;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    // Stage 2 holds everything while the consumer stalls, so outputs stay stable.
    out_valid_d = out_valid_q;
    y_d         = y_q;
    flags_d     = flags_q;
    if (s2_adv) begin
      out_valid_d          = s1_valid_q;
      y_d                  = fu_y;
      flags_d[FLAG_ZERO]   = fu_zero;
      flags_d[FLAG_CARRY]  = fu_carry;
      flags_d[FLAG_OVF]    = fu_ovf;
    end

    op_count_d = op_count_q;
    if (out_valid_q & bus.out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_AND;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = flags_q[FLAG_ZERO];
  assign bus.carry     = flags_q[FLAG_CARRY];
  assign bus.ovf       = flags_q[FLAG_OVF];
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_pipe_stage.sv
// tb/tb_alu_pipe_stage.sv - directed self-checking bench for alu_pipe_stage
module tb_alu_pipe_stage;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  int   exp_count;
  int   consumed;
  logic wrap_done;

  alu_pipe_stage_if #(.WIDTH(32)) bus ();

  alu_pipe_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input alu_op_t top, input logic [31:0] ey,
                        input logic ez, input logic ec, input logic ev);
    bus.a        = ta;
    bus.b        = tb_v;
    bus.op       = top;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_early_valid"}, 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'h1);
    check({tag, "_y"},     bus.y,               ey);
    check({tag, "_zero"},  32'(bus.zero),       32'(ez));
    check({tag, "_carry"}, 32'(bus.carry),      32'(ec));
    check({tag, "_ovf"},   32'(bus.ovf),        32'(ev));
    @(negedge clk);
    exp_count++;
    check({tag, "_count"}, 32'(bus.op_count), 32'(exp_count));
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    exp_count     = 0;
    consumed      = 0;
    wrap_done     = 1'b0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = OP_AND;
    bus.out_ready = 1'b0;

    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_y",         bus.y,              32'h0);
    check("rst_flags",     {29'h0, bus.ovf, bus.carry, bus.zero}, 32'h0);
    check("rst_count",     32'(bus.op_count),  32'h0);
    check("rst_in_ready",  32'(bus.in_ready),  32'h1);
    repeat (2) @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;

    run_op("and",      32'h0000_0005, 32'hFFFF_FFFD, OP_AND, 32'h0000_0005, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("add_cry",  32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_op("sub",      32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
    run_op("slt",      32'hFFFF_FFFF, 32'h0000_0001, OP_SLT, 32'h0000_0001, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 0;

    // Backpressure: two accepts fill both stages, then the stall is released.
    bus.out_ready = 1'b0;
    bus.a = 32'hF0F0_0000; bus.b = 32'h0000_0F0F; bus.op = OP_OR; bus.in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready_after_1", 32'(bus.in_ready), 32'h1);
    bus.a = 32'hFF00_FF00; bus.b = 32'h0FF0_0FF0; bus.op = OP_XOR;
    @(negedge clk);
    check("bp_ready_after_2", 32'(bus.in_ready), 32'h0);
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0004; bus.op = OP_SLL;
    @(negedge clk);
    check("bp_hold_ready", 32'(bus.in_ready),  32'h0);
    check("bp_hold_valid", 32'(bus.out_valid), 32'h1);
    check("bp_hold_y",     bus.y,              32'hF0F0_0F0F);
    check("bp_hold_count", 32'(bus.op_count),  32'h0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    check("bp_res1_y",     bus.y,             32'hF0F0_F0F0);
    check("bp_res1_count", 32'(bus.op_count), 32'h1);
    bus.a = 32'h8000_0000; bus.b = 32'h0000_001F; bus.op = OP_SRL;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_res2_y",     bus.y,             32'h0000_0010);
    check("bp_res2_count", 32'(bus.op_count), 32'h2);
    @(negedge clk);
    check("bp_res3_y",     bus.y,             32'h0000_0001);
    check("bp_res3_valid", 32'(bus.out_valid), 32'h1);
    check("bp_res3_count", 32'(bus.op_count), 32'h3);
    @(negedge clk);
    check("bp_end_valid",  32'(bus.out_valid), 32'h0);
    check("bp_end_count",  32'(bus.op_count),  32'h4);

    // Reset with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0001; bus.op = OP_ADD; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 32'h0000_0002;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_full_valid", 32'(bus.out_valid), 32'h1);
    check("mid_full_ready", 32'(bus.in_ready),  32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_count", 32'(bus.op_count),  32'h0);
    check("mid_rst_ready", 32'(bus.in_ready),  32'h1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mid_no_stale_%0d", i), 32'(bus.out_valid), 32'h0);
    end

    // op_count wrap with continuous streaming.
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0002; bus.op = OP_ADD; bus.in_valid = 1'b1;
    for (int c = 0; c < 70000 && !wrap_done; c++) begin
      @(negedge clk);
      if (consumed == 65535) begin
        check("wrap_ffff", 32'(bus.op_count), 32'h0000_FFFF);
        wrap_done = 1'b1;
      end else if (bus.out_valid) begin
        consumed++;
      end
    end
    check("wrap_reached", 32'(wrap_done), 32'h1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("wrap_zero", 32'(bus.op_count), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
